iqmap_multi: RTL and testbench

IQMAP_MULTI -- requirements
Module: iqmap_multi

---
 rtl/iqmap_pkg.sv | 39 +++
 rtl/iqmap_lut.sv | 61 ++++++
 rtl/iqmap_multi.sv | 118 +++++++++++
 tb/tb_iqmap_multi.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iqmap_pkg.sv
// rtl/iqmap_pkg.sv - mode encodings and constellation helpers for the IQ mapper
package iqmap_pkg;

    localparam logic [1:0] MODE_BPSK  = 2'd0;
    localparam logic [1:0] MODE_QPSK  = 2'd1;
    localparam logic [1:0] MODE_16QAM = 2'd2;
    localparam logic [1:0] MODE_64QAM = 2'd3;

    // Bits consumed per symbol for each modulation.
    function automatic logic [2:0] bps_of(input logic [1:0] mode);
        case (mode)
            MODE_BPSK:  return 3'd1;
            MODE_QPSK:  return 3'd2;
            MODE_16QAM: return 3'd4;
            default:    return 3'd6;
        endcase
    endfunction

    // Mask selecting the symbol bits of the current mode out of the 6 LSBs.
    function automatic logic [5:0] sym_mask(input logic [1:0] mode);
        case (mode)
            MODE_BPSK:  return 6'b000001;
            MODE_QPSK:  return 6'b000011;
            MODE_16QAM: return 6'b001111;
            default:    return 6'b111111;
        endcase
    endfunction

    // 64QAM Gray-coded magnitude in units of the constellation amplitude.
    function automatic logic [2:0] gray_mag(input logic [1:0] code);
        case (code)
            2'b00:   return 3'd1;
            2'b01:   return 3'd3;
            2'b11:   return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/iqmap_lut.sv
// rtl/iqmap_lut.sv - combinational symbol to (xr, xi) constellation mapper
module iqmap_lut
    import iqmap_pkg::*;
#(
    parameter int OUT_W    = 11,
    parameter int AMP_UNIT = 2
) (
    input  logic [1:0]              mode,
    input  logic [5:0]              sym,
    output logic signed [OUT_W-1:0] xr,
    output logic signed [OUT_W-1:0] xi
);

    localparam logic signed [OUT_W-1:0] AMP = OUT_W'(AMP_UNIT);

    logic [2:0]              mag_r;
    logic [2:0]              mag_i;
    logic                    pos_r;
    logic                    pos_i;
    logic signed [OUT_W-1:0] mag_rw;
    logic signed [OUT_W-1:0] mag_iw;
    logic signed [OUT_W-1:0] abs_r;
    logic signed [OUT_W-1:0] abs_i;

    // Split the symbol into sign and magnitude per axis, then scale by the unit amplitude.
    always_comb begin
        mag_r = 3'd1;
        mag_i = 3'd1;
        pos_r = 1'b0;
        pos_i = 1'b0;
        case (mode)
            MODE_BPSK: begin
                pos_r = sym[0];
                mag_i = 3'd0;
            end
            MODE_QPSK: begin
                pos_r = sym[1];
                pos_i = sym[0];
            end
            MODE_16QAM: begin
                pos_r = sym[3];
                pos_i = sym[2];
                mag_r = sym[1] ? 3'd3 : 3'd1;
                mag_i = sym[0] ? 3'd3 : 3'd1;
            end
            default: begin
                pos_r = sym[5];
                pos_i = sym[4];
                mag_r = gray_mag(sym[3:2]);
                mag_i = gray_mag(sym[1:0]);
            end
        endcase
        mag_rw = OUT_W'(mag_r);
        mag_iw = OUT_W'(mag_i);
        abs_r  = mag_rw * AMP;
        abs_i  = mag_iw * AMP;
        xr     = pos_r ? abs_r : -abs_r;
        xi     = pos_i ? abs_i : -abs_i;
    end

endmodule

// File: rtl/iqmap_multi.sv
// rtl/iqmap_multi.sv - multi-mode IQ mapper fed from a first-word-fall-through FIFO
module iqmap_multi
    import iqmap_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int OUT_W    = 11,
    parameter int AMP_UNIT = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ce,
    input  logic [1:0]              mode,
    input  logic                    valid_i,
    input  logic [DATA_W-1:0]       reader_data,
    output logic                    reader_en,
    output logic signed [OUT_W-1:0] xr,
    output logic signed [OUT_W-1:0] xi,
    output logic                    valid_o,
    output logic                    valid_raw,
    output logic [5:0]              raw
);

    if (DATA_W < 6) begin : g_bad_data_w
        $error("iqmap_multi: DATA_W must be at least 6");
    end
    if (7 * AMP_UNIT > (2 ** (OUT_W - 1)) - 1) begin : g_bad_amp
        $error("iqmap_multi: 7*AMP_UNIT does not fit in OUT_W");
    end

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BPSK  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_QPSK  = CNT_W'(DATA_W / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_16QAM = CNT_W'(DATA_W / 4 - 1);
    localparam logic [CNT_W-1:0] LAST_64QAM = CNT_W'(DATA_W / 6 - 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [0:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_last;
    logic [DATA_W-1:0]       sreg;
    logic [1:0]              mode_l;
    logic                    pop;
    logic                    chunk_end;
    logic                    accept;
    logic signed [OUT_W-1:0] map_r;
    logic signed [OUT_W-1:0] map_i;

    // Index of the last whole symbol in a chunk; leftover top bits are never reached.
    always_comb begin
        cnt_last = LAST_BPSK;
        case (mode_l)
            MODE_BPSK:  cnt_last = LAST_BPSK;
            MODE_QPSK:  cnt_last = LAST_QPSK;
            MODE_16QAM: cnt_last = LAST_16QAM;
            default:    cnt_last = LAST_64QAM;
        endcase
    end

    assign chunk_end = (state == S_ACTIVE) && (cnt == cnt_last);
    assign accept    = ce && valid_i && ((state == S_IDLE) || chunk_end);
    assign reader_en = pop & ce;
    assign valid_raw = valid_o;

    // Chunk sequencing: accept, shift out one symbol per ce cycle, chain or drop to idle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            sreg   <= '0;
            mode_l <= MODE_BPSK;
            pop    <= 1'b0;
        end else if (ce) begin
            pop <= accept;
            if (accept) begin
                state  <= S_ACTIVE;
                sreg   <= reader_data;
                mode_l <= mode;
                cnt    <= '0;
            end else if (chunk_end) begin
                // Clearing here keeps discarded top bits off raw while idle.
                state <= S_IDLE;
                sreg  <= '0;
                cnt   <= '0;
            end else if (state == S_ACTIVE) begin
                sreg <= sreg >> bps_of(mode_l);
                cnt  <= cnt + 1'b1;
            end
        end
    end

    iqmap_lut #(
        .OUT_W    (OUT_W),
        .AMP_UNIT (AMP_UNIT)
    ) u_lut (
        .mode (mode_l),
        .sym  (sreg[5:0]),
        .xr   (map_r),
        .xi   (map_i)
    );

    // Output register stage: sample, raw symbol bits and validity track each other.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            xr      <= '0;
            xi      <= '0;
            raw     <= '0;
            valid_o <= 1'b0;
        end else if (ce) begin
            xr      <= map_r;
            xi      <= map_i;
            raw     <= sreg[5:0] & sym_mask(mode_l);
            valid_o <= (state == S_ACTIVE);
        end
    end

endmodule

// File: tb/tb_iqmap_multi.sv
// tb/tb_iqmap_multi.sv - directed self-checking bench for iqmap_multi
module tb_iqmap_multi;

    localparam logic [127:0] D16 = {2{64'hFEDCBA9876543210}};
    localparam logic [127:0] D64 = {2'b11, 120'h123456789ABCDEF0123456789ABCDE, 6'h2E};
    localparam logic [127:0] DB  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] DQ1 = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] DQ2 = 128'h5A5A3C3CC3C3A5A50F0FF0F012488421;
    localparam logic [127:0] DC  = 128'h0123456789ABCDEF13579BDF02468ACE;

    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic               ce = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic               valid_i = 1'b0;
    logic [127:0]       reader_data = '0;
    logic               reader_en;
    logic signed [10:0] xr;
    logic signed [10:0] xi;
    logic               valid_o;
    logic               valid_raw;
    logic [5:0]         raw;

    int checks = 0;
    int passed = 0;

    iqmap_multi #(
        .DATA_W   (128),
        .OUT_W    (11),
        .AMP_UNIT (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ce          (ce),
        .mode        (mode),
        .valid_i     (valid_i),
        .reader_data (reader_data),
        .reader_en   (reader_en),
        .xr          (xr),
        .xi          (xi),
        .valid_o     (valid_o),
        .valid_raw   (valid_raw),
        .raw         (raw)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected {xr, xi, raw} for symbol k of a chunk, amplitude unit 2.
    function automatic logic [27:0] exp_out(input int m, input logic [127:0] chunk, input int k);
        logic [127:0] t;
        logic [5:0]   s;
        logic [5:0]   eraw;
        int           bps;
        int           mr;
        int           mi;
        int           er;
        int           ei;
        bps = (m == 0) ? 1 : (m == 1) ? 2 : (m == 2) ? 4 : 6;
        t = chunk >> (bps * k);
        s = t[5:0];
        case (m)
            0: begin
                eraw = {5'b0, s[0]};
                er = s[0] ? 2 : -2;
                ei = 0;
            end
            1: begin
                eraw = {4'b0, s[1:0]};
                er = s[1] ? 2 : -2;
                ei = s[0] ? 2 : -2;
            end
            2: begin
                eraw = {2'b0, s[3:0]};
                mr = s[1] ? 6 : 2;
                mi = s[0] ? 6 : 2;
                er = s[3] ? mr : -mr;
                ei = s[2] ? mi : -mi;
            end
            default: begin
                eraw = s;
                case (s[3:2])
                    2'b00: mr = 2;
                    2'b01: mr = 6;
                    2'b11: mr = 10;
                    default: mr = 14;
                endcase
                case (s[1:0])
                    2'b00: mi = 2;
                    2'b01: mi = 6;
                    2'b11: mi = 10;
                    default: mi = 14;
                endcase
                er = s[5] ? mr : -mr;
                ei = s[4] ? mi : -mi;
            end
        endcase
        return {11'(er), 11'(ei), eraw};
    endfunction

    task automatic test_reset();
        RST = 1'b0;
        ce  = 1'b1;
        repeat (3) tick();
        checks++;
        if ({valid_o, valid_raw, reader_en, xr, xi, raw} !== 31'b0)
            $display("FAIL reset_state: got %h want 0", {valid_o, valid_raw, reader_en, xr, xi, raw});
        else passed++;
        RST = 1'b1;
        repeat (3) tick();
        checks++;
        if ({valid_o, reader_en} !== 2'b00)
            $display("FAIL reset_release_idle: got %b want 00", {valid_o, reader_en});
        else passed++;
    endtask

    task automatic test_16qam();
        int nv;
        int pulses;
        int first;
        nv = 0;
        pulses = 0;
        first = -1;
        mode = 2'd2;
        reader_data = D16;
        valid_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 0) valid_i = 1'b0;
            if (reader_en) pulses++;
            if (valid_o) begin
                if (first < 0) first = c;
                checks++;
                if ({valid_raw, xr, xi, raw} !== {1'b1, exp_out(2, D16, nv)})
                    $display("FAIL qam16_sym%0d: got %h want %h", nv, {valid_raw, xr, xi, raw}, {1'b1, exp_out(2, D16, nv)});
                else passed++;
                nv++;
            end
        end
        checks++;
        if (nv !== 32) $display("FAIL qam16_count: got %0d want 32", nv); else passed++;
        checks++;
        if (pulses !== 1) $display("FAIL qam16_pops: got %0d want 1", pulses); else passed++;
        checks++;
        if (first !== 1) $display("FAIL qam16_latency: got %0d want 1", first); else passed++;
    endtask

    task automatic test_64qam();
        int nv;
        nv = 0;
        mode = 2'd3;
        reader_data = D64;
        valid_i = 1'b1;
        for (int c = 0; c < 26; c++) begin
            tick();
            if (c == 0) valid_i = 1'b0;
            if (c == 1) begin
                checks++;
                if (xr !== 11'sd10 || xi !== -11'sd14)
                    $display("FAIL qam64_first: got %0d,%0d want 10,-14", xr, xi);
                else passed++;
            end
            if (c == 22) begin
                checks++;
                if ({valid_o, raw} !== 7'b0)
                    $display("FAIL qam64_idle_raw: got %b want 0", {valid_o, raw});
                else passed++;
            end
            if (valid_o) begin
                checks++;
                if ({xr, xi, raw} !== exp_out(3, D64, nv))
                    $display("FAIL qam64_sym%0d: got %h want %h", nv, {xr, xi, raw}, exp_out(3, D64, nv));
                else passed++;
                nv++;
            end
        end
        checks++;
        if (nv !== 21) $display("FAIL qam64_count: got %0d want 21", nv); else passed++;
    endtask

    task automatic test_mode_latch();
        logic [27:0] e;
        mode = 2'd0;
        reader_data = DB;
        valid_i = 1'b1;
        for (int c = 0; c < 156; c++) begin
            tick();
            if (c == 0) begin
                mode = 2'd3;
                valid_i = 1'b0;
            end
            if (c == 100) begin
                valid_i = 1'b1;
                reader_data = D64;
            end
            if (c == 128) valid_i = 1'b0;
            checks++;
            if ({valid_o, reader_en} !== {(c >= 1 && c <= 149), (c == 0 || c == 128)})
                $display("FAIL latch_ctrl_c%0d: got %b want %b", c, {valid_o, reader_en}, {(c >= 1 && c <= 149), (c == 0 || c == 128)});
            else passed++;
            if (c >= 1 && c <= 149) begin
                e = (c <= 128) ? exp_out(0, DB, c - 1) : exp_out(3, D64, c - 129);
                checks++;
                if ({xr, xi, raw} !== e)
                    $display("FAIL latch_sym_c%0d: got %h want %h", c, {xr, xi, raw}, e);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [27:0] e;
        mode = 2'd1;
        reader_data = DQ1;
        valid_i = 1'b1;
        for (int c = 0; c < 132; c++) begin
            tick();
            if (c == 0) reader_data = DQ2;
            if (c == 64) valid_i = 1'b0;
            checks++;
            if ({valid_o, reader_en} !== {(c >= 1 && c <= 128), (c == 0 || c == 64)})
                $display("FAIL b2b_ctrl_c%0d: got %b want %b", c, {valid_o, reader_en}, {(c >= 1 && c <= 128), (c == 0 || c == 64)});
            else passed++;
            if (c >= 1 && c <= 128) begin
                e = (c <= 64) ? exp_out(1, DQ1, c - 1) : exp_out(1, DQ2, c - 65);
                checks++;
                if ({xr, xi, raw} !== e)
                    $display("FAIL b2b_sym_c%0d: got %h want %h", c, {xr, xi, raw}, e);
                else passed++;
            end
        end
    endtask

    task automatic test_ce_hold();
        logic [28:0] snap;
        mode = 2'd2;
        reader_data = DC;
        valid_i = 1'b1;
        ce = 1'b1;
        tick();
        valid_i = 1'b0;
        ce = 1'b0;
        for (int h = 0; h < 2; h++) begin
            tick();
            checks++;
            if ({reader_en, valid_o} !== 2'b00)
                $display("FAIL ce_pop_gated%0d: got %b want 00", h, {reader_en, valid_o});
            else passed++;
        end
        ce = 1'b1;
        #1;
        checks++;
        if (reader_en !== 1'b1) $display("FAIL ce_pop_release: got %b want 1", reader_en); else passed++;
        tick();
        for (int k = 0; k < 32; k++) begin
            checks++;
            if ({valid_o, xr, xi, raw} !== {1'b1, exp_out(2, DC, k)})
                $display("FAIL ce_sym%0d: got %h want %h", k, {valid_o, xr, xi, raw}, {1'b1, exp_out(2, DC, k)});
            else passed++;
            if (k == 5) begin
                snap = {valid_o, xr, xi, raw};
                ce = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    checks++;
                    if ({valid_o, xr, xi, raw, reader_en} !== {snap, 1'b0})
                        $display("FAIL ce_hold%0d: got %h want %h", h, {valid_o, xr, xi, raw, reader_en}, {snap, 1'b0});
                    else passed++;
                end
                ce = 1'b1;
            end
            tick();
        end
        checks++;
        if (valid_o !== 1'b0) $display("FAIL ce_end: got %b want 0", valid_o); else passed++;
    endtask

    task automatic test_reset_mid();
        int nv;
        int np;
        mode = 2'd2;
        reader_data = D16;
        valid_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c == 0) valid_i = 1'b0;
        end
        checks++;
        if ({valid_o, xr, xi, raw} !== {1'b1, exp_out(2, D16, 10)})
            $display("FAIL rstmid_sym10: got %h want %h", {valid_o, xr, xi, raw}, {1'b1, exp_out(2, D16, 10)});
        else passed++;
        RST = 1'b0;
        #1;
        checks++;
        if ({valid_o, valid_raw, reader_en, xr, xi, raw} !== 31'b0)
            $display("FAIL rstmid_zero: got %h want 0", {valid_o, valid_raw, reader_en, xr, xi, raw});
        else passed++;
        repeat (2) tick();
        RST = 1'b1;
        nv = 0;
        np = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (valid_o) nv++;
            if (reader_en) np++;
        end
        checks++;
        if (nv !== 0 || np !== 0)
            $display("FAIL rstmid_stays_idle: got valid %0d pops %0d want 0 0", nv, np);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_16qam();
        test_64qam();
        test_mode_latch();
        test_back_to_back();
        test_ce_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
